// File: rtl/riscv_pkg.sv
// Shared types for the writeback stage: result select encoding, load funct3 codes and
// the MEM/WB pipeline register layout.
package riscv_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_IMM  = 2'b11
  } result_src_e;

  localparam logic [2:0] LOAD_F3_B  = 3'b000;
  localparam logic [2:0] LOAD_F3_H  = 3'b001;
  localparam logic [2:0] LOAD_F3_W  = 3'b010;
  localparam logic [2:0] LOAD_F3_BU = 3'b100;
  localparam logic [2:0] LOAD_F3_HU = 3'b101;

  typedef struct packed {
    logic        valid;
    logic        we;
    result_src_e src;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus4;
    logic [31:0] immext;
  } mem_wb_t;

endpackage

// File: rtl/data_writeback_stage_block_load_extender.sv
// Picks the byte/half lane out of a word-aligned read and sign- or zero-extends it.
module load_extender
  import riscv_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    unique case (offset)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    // Halfword loads ignore offset[0]; misalignment is not trapped here.
    half_sel = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data = word;
    case (funct3)
      LOAD_F3_B:  data = {{24{byte_sel[7]}}, byte_sel};
      LOAD_F3_BU: data = {24'h0, byte_sel};
      LOAD_F3_H:  data = {{16{half_sel[15]}}, half_sel};
      LOAD_F3_HU: data = {16'h0, half_sel};
      LOAD_F3_W:  data = word;
      default:    data = word;
    endcase
  end

endmodule

// File: rtl/data_writeback_stage_block.sv
// MEM/WB pipeline register, final result select, regfile write port, decode bypass
// compare and retired-instruction counter.
module data_writeback_stage_block
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CNT_WIDTH = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic                 i_m_valid,
  input  logic [XLEN-1:0]      i_m_alu_result,
  input  logic [XLEN-1:0]      i_m_read_data,
  input  logic [XLEN-1:0]      i_m_pc_plus4,
  input  logic [XLEN-1:0]      i_m_immext,
  input  logic [4:0]           i_m_rd,
  input  logic [2:0]           i_m_funct3,
  input  logic                 i_m_en_regfile_write,
  input  logic [1:0]           i_m_mux_result_src,
  input  logic [4:0]           i_d_rs1,
  input  logic [4:0]           i_d_rs2,
  output logic [4:0]           o_result_addr,
  output logic [XLEN-1:0]      o_final_result,
  output logic                 o_en_regfile_write,
  output logic                 o_w_valid,
  output logic                 o_fwd_rs1,
  output logic                 o_fwd_rs2,
  output logic [CNT_WIDTH-1:0] o_retired_count
);

  mem_wb_t              wb_d, wb_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [31:0]          load_data;

  always_comb begin
    wb_d            = '0;
    wb_d.valid      = i_m_valid;
    wb_d.we         = i_m_en_regfile_write;
    wb_d.src        = result_src_e'(i_m_mux_result_src);
    wb_d.funct3     = i_m_funct3;
    wb_d.rd         = i_m_rd;
    wb_d.alu_result = i_m_alu_result;
    wb_d.read_data  = i_m_read_data;
    wb_d.pc_plus4   = i_m_pc_plus4;
    wb_d.immext     = i_m_immext;
  end

  // Flush only clears control; the stale data fields are masked by valid/we.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wb_q <= '0;
    end else if (i_flush) begin
      wb_q.valid <= 1'b0;
      wb_q.we    <= 1'b0;
      wb_q.rd    <= 5'd0;
    end else if (!i_stall) begin
      wb_q <= wb_d;
    end
  end

  // A stalled WB instruction retires once, on the cycle the stall releases.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else if (wb_q.valid && !i_stall) begin
      count_q <= count_q + 1'b1;
    end
  end

  load_extender u_load_extender (
    .word   (wb_q.read_data),
    .offset (wb_q.alu_result[1:0]),
    .funct3 (wb_q.funct3),
    .data   (load_data)
  );

  always_comb begin
    o_final_result = wb_q.alu_result;
    unique case (wb_q.src)
      RES_ALU:  o_final_result = wb_q.alu_result;
      RES_LOAD: o_final_result = load_data;
      RES_PC4:  o_final_result = wb_q.pc_plus4;
      RES_IMM:  o_final_result = wb_q.immext;
      default:  o_final_result = wb_q.alu_result;
    endcase
  end

  assign o_result_addr      = wb_q.rd;
  assign o_w_valid          = wb_q.valid;
  assign o_en_regfile_write = wb_q.valid & wb_q.we & (wb_q.rd != 5'd0);
  assign o_fwd_rs1          = o_en_regfile_write & (wb_q.rd == i_d_rs1);
  assign o_fwd_rs2          = o_en_regfile_write & (wb_q.rd == i_d_rs2);
  assign o_retired_count    = count_q;

endmodule

// File: tb/tb_data_writeback_stage_block.sv
// Scoreboard bench: the driver pushes the expected WB view per cycle, a negedge monitor
// pops and compares whenever the stage presents a valid instruction.
module tb_data_writeback_stage_block;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        m_valid, m_we;
  logic [31:0] m_alu, m_rdata, m_pc4, m_imm;
  logic [4:0]  m_rd, d_rs1, d_rs2;
  logic [2:0]  m_f3;
  logic [1:0]  m_src;
  logic [4:0]  o_addr;
  logic [31:0] o_res;
  logic        o_en, o_valid, o_f1, o_f2;
  logic [63:0] o_cnt;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] res;
    logic        en;
    logic [63:0] cnt;
    logic        f1;
    logic        f2;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference state of the WB slot, advanced once per issued edge.
  logic        r_valid = 1'b0;
  logic        r_we    = 1'b0;
  logic [4:0]  r_rd    = 5'd0;
  logic [31:0] r_res   = 32'd0;
  logic [63:0] r_cnt   = 64'd0;

  always #5 clk = ~clk;

  data_writeback_stage_block dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_stall              (stall),
    .i_flush              (flush),
    .i_m_valid            (m_valid),
    .i_m_alu_result       (m_alu),
    .i_m_read_data        (m_rdata),
    .i_m_pc_plus4         (m_pc4),
    .i_m_immext           (m_imm),
    .i_m_rd               (m_rd),
    .i_m_funct3           (m_f3),
    .i_m_en_regfile_write (m_we),
    .i_m_mux_result_src   (m_src),
    .i_d_rs1              (d_rs1),
    .i_d_rs2              (d_rs2),
    .o_result_addr        (o_addr),
    .o_final_result       (o_res),
    .o_en_regfile_write   (o_en),
    .o_w_valid            (o_valid),
    .o_fwd_rs1            (o_f1),
    .o_fwd_rs2            (o_f2),
    .o_retired_count      (o_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one MEM-stage slot, let one edge pass, then publish what WB must show.
  task automatic issue(input logic v, input logic we, input logic [4:0] rd,
                       input logic [1:0] src, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] exp_res, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic st, input logic fl);
    exp_t e;
    logic en;
    m_valid = v; m_we = we; m_rd = rd; m_src = src; m_f3 = f3; m_alu = alu;
    stall = st; flush = fl;
    @(posedge clk);
    if (r_valid && !st) r_cnt++;
    if (fl) begin
      r_valid = 1'b0; r_we = 1'b0; r_rd = 5'd0;
    end else if (!st) begin
      r_valid = v; r_we = we; r_rd = rd; r_res = exp_res;
    end
    #2;
    d_rs1 = rs1; d_rs2 = rs2;
    en = r_valid && r_we && (r_rd != 5'd0);
    if (r_valid) begin
      e.addr = r_rd; e.res = r_res; e.en = en; e.cnt = r_cnt;
      e.f1 = en && (r_rd == rs1); e.f2 = en && (r_rd == rs2);
      q.push_back(e);
    end else begin
      check("bubble_valid", {63'd0, o_valid}, 64'd0);
      check("bubble_we", {63'd0, o_en}, 64'd0);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && o_valid) begin
        if (q.size() == 0) begin
          check("unexpected_valid", {63'd0, o_valid}, 64'd0);
        end else begin
          e = q.pop_front();
          check("addr", {59'd0, o_addr}, {59'd0, e.addr});
          check("result", {32'd0, o_res}, {32'd0, e.res});
          check("we", {63'd0, o_en}, {63'd0, e.en});
          check("count", o_cnt, e.cnt);
          check("fwd_rs1", {63'd0, o_f1}, {63'd0, e.f1});
          check("fwd_rs2", {63'd0, o_f2}, {63'd0, e.f2});
        end
      end
    end
  end

  initial begin : driver
    localparam logic [31:0] Word = 32'h80FF7F01;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    m_valid = 1'b0; m_we = 1'b0; m_rd = 5'd0; m_src = 2'd0; m_f3 = 3'd0;
    m_alu = 32'd0; m_rdata = Word; m_pc4 = 32'h104; m_imm = 32'hABCDE000;
    d_rs1 = 5'd0; d_rs2 = 5'd0;
    #1;
    check("rst_valid", {63'd0, o_valid}, 64'd0);
    check("rst_we", {63'd0, o_en}, 64'd0);
    check("rst_addr", {59'd0, o_addr}, 64'd0);
    check("rst_result", {32'd0, o_res}, 64'd0);
    check("rst_count", o_cnt, 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    //     v  we rd     src   f3    alu            expected       rs1    rs2   st    fl
    issue(1, 1, 5'd5, 2'd0, 3'd0, 32'h1234,     32'h1234,     5'd0, 5'd0, 0, 0);
    issue(1, 1, 5'd6, 2'd1, 3'd0, 32'h2003,     32'hFFFFFF80, 5'd0, 5'd0, 0, 0);
    issue(1, 1, 5'd6, 2'd1, 3'd4, 32'h2001,     32'h0000007F, 5'd0, 5'd0, 0, 0);
    issue(1, 1, 5'd6, 2'd1, 3'd1, 32'h2002,     32'hFFFF80FF, 5'd0, 5'd0, 0, 0);
    issue(1, 1, 5'd6, 2'd1, 3'd1, 32'h2003,     32'hFFFF80FF, 5'd0, 5'd0, 0, 0);
    issue(1, 1, 5'd6, 2'd1, 3'd5, 32'h2000,     32'h00007F01, 5'd0, 5'd0, 0, 0);
    issue(1, 1, 5'd6, 2'd1, 3'd2, 32'h2000,     32'h80FF7F01, 5'd0, 5'd0, 0, 0);
    issue(1, 1, 5'd6, 2'd1, 3'd3, 32'h2002,     32'h80FF7F01, 5'd0, 5'd0, 0, 0);
    // x0 destination: no write, no bypass even when decode reads x0
    issue(1, 1, 5'd0, 2'd0, 3'd0, 32'hDEAD,     32'hDEAD,     5'd0, 5'd0, 0, 0);
    issue(1, 1, 5'd1, 2'd2, 3'd0, 32'h5555,     32'h00000104, 5'd1, 5'd0, 0, 0);
    issue(1, 1, 5'd2, 2'd3, 3'd0, 32'h6666,     32'hABCDE000, 5'd0, 5'd2, 0, 0);
    issue(1, 1, 5'd7, 2'd0, 3'd0, 32'h77,       32'h77,       5'd7, 5'd8, 0, 0);
    issue(1, 0, 5'd9, 2'd0, 3'd0, 32'h99,       32'h99,       5'd9, 5'd9, 0, 0);
    // stall three cycles: held outputs, bypass persists, one retire on release
    issue(1, 1, 5'd10, 2'd0, 3'd0, 32'hA0,      32'hA0,       5'd10, 5'd3, 0, 0);
    issue(1, 1, 5'd11, 2'd0, 3'd0, 32'hBB,      32'hBB,       5'd10, 5'd3, 1, 0);
    issue(1, 1, 5'd11, 2'd0, 3'd0, 32'hBB,      32'hBB,       5'd10, 5'd3, 1, 0);
    issue(1, 1, 5'd11, 2'd0, 3'd0, 32'hBB,      32'hBB,       5'd10, 5'd3, 1, 0);
    issue(0, 0, 5'd0, 2'd0, 3'd0, 32'h0,        32'h0,        5'd0, 5'd0, 0, 0);
    // flush beats stall
    issue(1, 1, 5'd12, 2'd0, 3'd0, 32'hC0,      32'hC0,       5'd0, 5'd0, 0, 0);
    issue(1, 1, 5'd13, 2'd0, 3'd0, 32'hD0,      32'hD0,       5'd0, 5'd0, 1, 1);
    check("flush_addr", {59'd0, o_addr}, 64'd0);
    // flush alone: the instruction already in WB still retires
    issue(1, 1, 5'd14, 2'd0, 3'd0, 32'hE0,      32'hE0,       5'd0, 5'd0, 0, 0);
    issue(1, 1, 5'd15, 2'd0, 3'd0, 32'hF0,      32'hF0,       5'd0, 5'd0, 0, 1);
    issue(0, 0, 5'd0, 2'd0, 3'd0, 32'h0,        32'h0,        5'd0, 5'd0, 0, 0);
    check("flush_retire_count", o_cnt, r_cnt);

    // async reset between edges with an instruction in WB
    issue(1, 1, 5'd15, 2'd0, 3'd0, 32'h1515,    32'h1515,     5'd15, 5'd0, 0, 0);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("arst_valid", {63'd0, o_valid}, 64'd0);
    check("arst_we", {63'd0, o_en}, 64'd0);
    check("arst_addr", {59'd0, o_addr}, 64'd0);
    check("arst_fwd", {63'd0, o_f1}, 64'd0);
    check("arst_count", o_cnt, 64'd0);
    #1;
    rst = 1'b0;
    r_valid = 1'b0; r_we = 1'b0; r_rd = 5'd0; r_res = 32'd0; r_cnt = 64'd0;
    issue(1, 1, 5'd16, 2'd0, 3'd0, 32'h16,      32'h16,       5'd16, 5'd0, 0, 0);
    issue(0, 0, 5'd0, 2'd0, 3'd0, 32'h0,        32'h0,        5'd0, 5'd0, 0, 0);
    check("post_reset_count", o_cnt, 64'd1);

    @(negedge clk); #1;
    check("scoreboard_drained", {32'd0, q.size()}, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
